// File: rtl/cache_cmd_arbiter_if.sv
// Bundle of requester, response and controller signals for cache_cmd_arbiter.
// slave is the arbiter's view; master is the view of whatever drives it.
interface cache_cmd_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned KEY_W   = 16,
  parameter int unsigned VAL_W   = 32
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [2*NUM_REQ-1:0]     req_op;
  logic [KEY_W*NUM_REQ-1:0] req_key;
  logic [VAL_W*NUM_REQ-1:0] req_value;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic                     rsp_error;
  logic                     rsp_timeout;
  logic [VAL_W-1:0]         rsp_value;
  logic                     ctrl_enter;
  logic                     ctrl_en;
  logic [1:0]               ctrl_op;
  logic [KEY_W-1:0]         ctrl_key;
  logic [VAL_W-1:0]         ctrl_value;
  logic                     ctrl_done;
  logic                     ctrl_error;
  logic [VAL_W-1:0]         ctrl_rdata;
  logic                     busy;

  modport slave (
    input  req_valid, req_op, req_key, req_value, rsp_ready, ctrl_done, ctrl_error, ctrl_rdata,
    output req_ready, rsp_valid, rsp_error, rsp_timeout, rsp_value, ctrl_enter, ctrl_en,
    output ctrl_op, ctrl_key, ctrl_value, busy
  );

  modport master (
    output req_valid, req_op, req_key, req_value, rsp_ready, ctrl_done, ctrl_error, ctrl_rdata,
    input  req_ready, rsp_valid, rsp_error, rsp_timeout, rsp_value, ctrl_enter, ctrl_en,
    input  ctrl_op, ctrl_key, ctrl_value, busy
  );
endinterface

// File: rtl/cache_cmd_arbiter.sv
// Round-robin arbiter that serialises GET/UPSERT/DELETE commands from several
// requesters onto a single cache controller, with a completion timeout.
module cache_cmd_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned KEY_W   = 16,
  parameter int unsigned VAL_W   = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input logic                clk,
  input logic                rst,
  cache_cmd_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  localparam logic [1:0] OpGet      = 2'b00;
  localparam logic [1:0] OpReserved = 2'b11;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [VAL_W-1:0]   cmd_val_q, cmd_val_d;
  logic [VAL_W-1:0]   rsp_val_q, rsp_val_d;
  logic               err_q, err_d;
  logic               tmo_q, tmo_d;

  logic [1:0]         op_arr  [NUM_REQ];
  logic [KEY_W-1:0]   key_arr [NUM_REQ];
  logic [VAL_W-1:0]   val_arr [NUM_REQ];
  logic               grant_vld;
  logic [PTR_W-1:0]   grant;
  logic [PTR_W-1:0]   grant_nxt;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_arr[g]  = bus.req_op[2*g +: 2];
    assign key_arr[g] = bus.req_key[KEY_W*g +: KEY_W];
    assign val_arr[g] = bus.req_value[VAL_W*g +: VAL_W];
  end

  // Round-robin search starting at ptr; first valid requester wins.
  always_comb begin
    int unsigned      idx;
    logic [PTR_W-1:0] idx_p;
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    idx_p     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx   = (32'(ptr_q) + i) % NUM_REQ;
      idx_p = PTR_W'(idx);
      if (!grant_vld && bus.req_valid[idx_p]) begin
        grant_vld = 1'b1;
        grant     = idx_p;
      end
    end
    grant_nxt = PTR_W'((32'(grant) + 1) % NUM_REQ);
  end

  // Next-state and latched-command/response logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    key_d     = key_q;
    cmd_val_d = cmd_val_q;
    rsp_val_d = rsp_val_q;
    err_d     = err_q;
    tmo_d     = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          owner_d   = grant;
          ptr_d     = grant_nxt;
          op_d      = op_arr[grant];
          key_d     = key_arr[grant];
          cmd_val_d = val_arr[grant];
          rsp_val_d = '0;
          tmo_d     = 1'b0;
          cnt_d     = '0;
          // Reserved op is rejected without touching the controller.
          if (op_arr[grant] == OpReserved) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            err_d   = 1'b0;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (bus.ctrl_error) begin
          err_d     = 1'b1;
          rsp_val_d = '0;
          state_d   = StResp;
        end else if (bus.ctrl_done) begin
          err_d     = 1'b0;
          rsp_val_d = (op_q == OpGet) ? bus.ctrl_rdata : '0;
          state_d   = StResp;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d     = 1'b1;
          tmo_d     = 1'b1;
          rsp_val_d = '0;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (bus.rsp_ready[owner_q]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and latched-command registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      key_q     <= '0;
      cmd_val_q <= '0;
      rsp_val_q <= '0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      key_q     <= key_d;
      cmd_val_q <= cmd_val_d;
      rsp_val_q <= rsp_val_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  // Output decode; everything is forced low while reset is asserted.
  always_comb begin
    bus.req_ready   = '0;
    bus.rsp_valid   = '0;
    bus.rsp_error   = 1'b0;
    bus.rsp_timeout = 1'b0;
    bus.rsp_value   = '0;
    bus.ctrl_enter  = 1'b0;
    bus.ctrl_en     = 1'b0;
    bus.ctrl_op     = '0;
    bus.ctrl_key    = '0;
    bus.ctrl_value  = '0;
    bus.busy        = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          if (grant_vld) bus.req_ready[grant] = 1'b1;
        end
        StIssue: begin
          bus.ctrl_enter = 1'b1;
          bus.ctrl_op    = op_q;
          bus.ctrl_key   = key_q;
          bus.ctrl_value = cmd_val_q;
          bus.busy       = 1'b1;
        end
        StWait: begin
          bus.ctrl_en    = 1'b1;
          bus.ctrl_op    = op_q;
          bus.ctrl_key   = key_q;
          bus.ctrl_value = cmd_val_q;
          bus.busy       = 1'b1;
        end
        StResp: begin
          bus.rsp_valid[owner_q] = 1'b1;
          bus.rsp_error          = err_q;
          bus.rsp_timeout        = tmo_q;
          bus.rsp_value          = rsp_val_q;
          bus.busy               = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_cmd_arbiter.sv
// Directed bench for cache_cmd_arbiter (NUM_REQ=2, TIMEOUT=4).
module tb_cache_cmd_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  cache_cmd_arbiter_if #(.NUM_REQ(2), .KEY_W(16), .VAL_W(32)) bus ();

  cache_cmd_arbiter #(
    .NUM_REQ(2),
    .KEY_W  (16),
    .VAL_W  (32),
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    bus.req_valid  = '0;
    bus.req_op     = '0;
    bus.req_key    = '0;
    bus.req_value  = '0;
    bus.rsp_ready  = '0;
    bus.ctrl_done  = 1'b0;
    bus.ctrl_error = 1'b0;
    bus.ctrl_rdata = '0;
  endtask

  // One full command from requester `who`. Controller answers on WAIT cycle
  // `delay` (negative: stays silent). Ends back in IDLE.
  task automatic run_cmd(input string tag, input int who, input logic [1:0] op,
                         input logic [15:0] key, input logic [31:0] wval, input int delay,
                         input logic done_in, input logic err_in, input logic [31:0] rdata,
                         input logic exp_err, input logic exp_tmo, input logic [31:0] exp_val,
                         input int exp_en);
    logic [1:0] oh;
    int         en_cnt;
    oh = 2'b01 << who;
    bus.req_valid = oh;
    bus.req_op[2*who +: 2]      = op;
    bus.req_key[16*who +: 16]   = key;
    bus.req_value[32*who +: 32] = wval;
    #1;
    check({tag, ".ready"}, bus.req_ready, oh);
    check({tag, ".idle_busy"}, bus.busy, 1'b0);
    tick();
    bus.req_valid = '0;
    #1;
    check({tag, ".enter"}, {bus.ctrl_enter, bus.ctrl_en}, 2'b10);
    check({tag, ".ctrl_cmd"}, {bus.ctrl_op, bus.ctrl_key, bus.ctrl_value}, {op, key, wval});
    check({tag, ".issue_ready"}, bus.req_ready, 2'b00);
    tick();
    en_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      bus.ctrl_done  = 1'b0;
      bus.ctrl_error = 1'b0;
      bus.ctrl_rdata = '0;
      if (c == delay) begin
        bus.ctrl_done  = done_in;
        bus.ctrl_error = err_in;
        bus.ctrl_rdata = rdata;
      end
      #1;
      if (bus.rsp_valid != 2'b00) break;
      if (bus.ctrl_en) en_cnt++;
      if (bus.ctrl_enter) en_cnt += 100;
      tick();
    end
    bus.ctrl_done  = 1'b0;
    bus.ctrl_error = 1'b0;
    bus.ctrl_rdata = '0;
    check({tag, ".en_cycles"}, en_cnt, exp_en);
    check({tag, ".rsp"}, {bus.rsp_valid, bus.rsp_error, bus.rsp_timeout, bus.rsp_value},
          {oh, exp_err, exp_tmo, exp_val});
    // Only non-owners ready: response must hold.
    bus.rsp_ready = ~oh;
    tick();
    #1;
    check({tag, ".rsp_hold"}, {bus.rsp_valid, bus.rsp_error, bus.rsp_timeout, bus.rsp_value},
          {oh, exp_err, exp_tmo, exp_val});
    bus.rsp_ready = oh;
    tick();
    bus.rsp_ready = '0;
    #1;
    check({tag, ".done_idle"}, {bus.busy, bus.rsp_valid}, 3'b000);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_inputs();
    rst = 1'b1;
    bus.req_valid = 2'b11;
    tick();
    tick();
    #1;
    check("reset.ready", bus.req_ready, 2'b00);
    check("reset.outs", {bus.rsp_valid, bus.rsp_error, bus.rsp_timeout, bus.rsp_value,
                         bus.ctrl_enter, bus.ctrl_en, bus.ctrl_op, bus.ctrl_key,
                         bus.ctrl_value, bus.busy}, '0);
    bus.req_valid = '0;
    rst = 1'b0;
    tick();

    // GET hit, controller answers on first WAIT cycle.
    run_cmd("get", 0, 2'b00, 16'h0012, 32'h0, 0, 1'b1, 1'b0, 32'hDEADBEEF,
            1'b0, 1'b0, 32'hDEADBEEF, 1);

    // Round-robin from ptr=0 with both requesters continuously valid.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_key   = 32'hBBBB_AAAA;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp_g;
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      check("rr.grant", bus.req_ready, exp_g);
      tick();
      #1;
      check("rr.issue_ready", bus.req_ready, 2'b00);
      tick();
      bus.ctrl_done = 1'b1;
      tick();
      bus.ctrl_done = 1'b0;
      bus.rsp_ready = 2'b11;
      #1;
      check("rr.rsp", {bus.rsp_valid, bus.req_ready}, {exp_g, 2'b00});
      tick();
      bus.rsp_ready = '0;
    end
    bus.req_valid = '0;
    bus.req_key   = '0;

    // UPSERT with error and done together: error wins.
    run_cmd("ups_err", 0, 2'b01, 16'h1234, 32'hCAFE0001, 1, 1'b1, 1'b1, 32'h55555555,
            1'b1, 1'b0, 32'h0, 2);
    // UPSERT success returns zero data even with rdata driven.
    run_cmd("ups_ok", 1, 2'b01, 16'h00A5, 32'h0BADF00D, 0, 1'b1, 1'b0, 32'h77777777,
            1'b0, 1'b0, 32'h0, 1);
    // Silent controller: four WAIT cycles then timeout.
    run_cmd("tmo", 1, 2'b00, 16'h4321, 32'h0, -1, 1'b0, 1'b0, 32'h0,
            1'b1, 1'b1, 32'h0, 4);
    // Completion in the last WAIT cycle beats the timeout.
    run_cmd("late_done", 0, 2'b00, 16'h0FED, 32'h0, 3, 1'b1, 1'b0, 32'h13579BDF,
            1'b0, 1'b0, 32'h13579BDF, 4);
    // DELETE, plain success.
    run_cmd("del", 1, 2'b10, 16'hFFFF, 32'h0, 2, 1'b1, 1'b0, 32'hFFFFFFFF,
            1'b0, 1'b0, 32'h0, 3);

    // Reserved op from req1: straight to response, no controller pulse.
    bus.req_valid = 2'b10;
    bus.req_op    = 4'b1100;
    #1;
    check("rsvd.ready", bus.req_ready, 2'b10);
    tick();
    bus.req_valid = '0;
    bus.req_op    = '0;
    #1;
    check("rsvd.rsp", {bus.ctrl_enter, bus.ctrl_en, bus.rsp_valid, bus.rsp_error,
                       bus.rsp_timeout}, 6'b00_10_10);
    bus.rsp_ready = 2'b10;
    tick();
    bus.rsp_ready = '0;

    // Reset mid-WAIT after a req0 grant (ptr would otherwise point at req1).
    bus.req_valid = 2'b01;
    bus.req_key   = 32'h0000_0099;
    tick();
    bus.req_valid = '0;
    tick();
    #1;
    check("rstwait.in_wait", {bus.ctrl_en, bus.busy}, 2'b11);
    rst = 1'b1;
    tick();
    #1;
    check("rstwait.outs", {bus.req_ready, bus.rsp_valid, bus.rsp_error, bus.rsp_timeout,
                           bus.rsp_value, bus.ctrl_enter, bus.ctrl_en, bus.ctrl_op,
                           bus.ctrl_key, bus.ctrl_value, bus.busy}, '0);
    rst = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    check("rstwait.grant0", bus.req_ready, 2'b01);
    bus.req_valid = '0;
    tick();
    tick();
    #1;
    check("rstwait.no_rsp", {bus.rsp_valid, bus.busy}, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cache_cmd_arbiter.md
CACHE_CMD_ARBITER -- requirements
Module: cache_cmd_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing the cache controller (2..8).
REQ-002 Parameter KEY_W, default 16, key width in bits.
REQ-003 Parameter VAL_W, default 32, value width in bits.
REQ-004 Parameter TIMEOUT, default 64, max cycles waited for controller completion (>=2).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 req_valid  in  NUM_REQ  per-requester command valid.
REQ-008 req_ready  out  NUM_REQ  per-requester command accepted (one-hot or zero).
REQ-009 req_op  in  2*NUM_REQ  per-requester op: 00 GET, 01 UPSERT, 10 DELETE, 11 reserved.
REQ-010 req_key  in  KEY_W*NUM_REQ  per-requester key.
REQ-011 req_value  in  VAL_W*NUM_REQ  per-requester write value (UPSERT only).
REQ-012 rsp_valid  out  NUM_REQ  response valid toward owning requester (one-hot or zero).
REQ-013 rsp_ready  in  NUM_REQ  per-requester response accept.
REQ-014 rsp_error  out  1  response carries error.
REQ-015 rsp_timeout  out  1  error caused by timeout.
REQ-016 rsp_value  out  VAL_W  read data (GET), else zero.
REQ-017 ctrl_enter  out  1  one-cycle pulse restarting controller sub-FSM.
REQ-018 ctrl_en  out  1  controller sub-FSM enable.
REQ-019 ctrl_op / ctrl_key / ctrl_value  out  2 / KEY_W / VAL_W  latched command toward controller.
REQ-020 ctrl_done / ctrl_error  in  1 / 1  controller completion / failure (e.g. UPSERT with no free entry).
REQ-021 ctrl_rdata  in  VAL_W  controller read data, valid with ctrl_done.
REQ-022 busy  out  1  high in any state except IDLE.

Function
REQ-023 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-024 IDLE: grant = first index with req_valid set, searching ptr, ptr+1, ... mod NUM_REQ; req_ready[grant]=1 combinationally, all other req_ready bits 0.
REQ-025 On IDLE accept: latch op/key/value and owner=grant, ptr <= (grant+1) mod NUM_REQ, go ISSUE; op 11 goes RESP directly with rsp_error=1, rsp_timeout=0, no ctrl activity.
REQ-026 No requester valid in IDLE: stay IDLE, ptr unchanged, req_ready all 0.
REQ-027 ISSUE: ctrl_enter=1, ctrl_en=0 for exactly one cycle, then WAIT.
REQ-028 WAIT: ctrl_en=1, ctrl_enter=0; wait counter cleared on entry, increments per WAIT cycle.
REQ-029 WAIT with ctrl_error=1: latch error=1, value=0, go RESP; error takes precedence if ctrl_done also 1.
REQ-030 WAIT with ctrl_done=1, ctrl_error=0: latch error=0, value=ctrl_rdata if op GET else 0, go RESP.
REQ-031 WAIT with counter reaching TIMEOUT-1 and no done/error: latch error=1, timeout=1, value=0, go RESP; completion in that same cycle wins over timeout.
REQ-032 RESP: rsp_valid[owner]=1, rsp_error/rsp_timeout/rsp_value stable until rsp_ready[owner]=1; then IDLE next cycle; rsp_ready of non-owners ignored.
REQ-033 ctrl_op/ctrl_key/ctrl_value SHALL hold latched command from ISSUE through WAIT; zero in IDLE.
REQ-034 Minimum accept-to-response latency: accept cycle N, ISSUE N+1, WAIT N+2, rsp_valid at N+3 if ctrl_done arrives at N+2.
REQ-035 New request SHALL NOT be accepted until returning to IDLE; at most one command outstanding.

Reset
REQ-036 rst=1 at a clock edge: state IDLE, ptr=0, owner=0, counter=0, latched op/key/value/error/timeout=0, from any state including mid-WAIT.
REQ-037 During/after reset: req_ready, rsp_valid, rsp_error, rsp_timeout, rsp_value, ctrl_enter, ctrl_en, ctrl_op, ctrl_key, ctrl_value, busy all 0; in-flight command discarded, no response.

Verification
REQ-038 Req0 GET key=0x0012, ctrl_done+ctrl_rdata=0xDEADBEEF one cycle into WAIT -> rsp_valid=01, rsp_value=0xDEADBEEF, rsp_error=0, 3 cycles after accept.
REQ-039 Req0 and req1 both valid continuously, ptr=0 -> grants 0,1,0,1 alternate; never two req_ready bits set.
REQ-040 UPSERT with ctrl_error=1 and ctrl_done=1 same cycle -> rsp_error=1, rsp_timeout=0, rsp_value=0.
REQ-041 TIMEOUT=4, controller silent -> ctrl_en high 4 cycles, then rsp_error=1, rsp_timeout=1.
REQ-042 Req1 op=11 -> no ctrl_enter pulse, rsp_valid=10 with rsp_error=1 cycle after accept.
REQ-043 rst asserted mid-WAIT with rsp_ready stalled -> all outputs 0 next cycle, next grant starts from req0.
